pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//   Control-flow sequencer for the 16-bit program counter. Accepts one control-flow op at a
//   time (next, relative jump, call, return, halt) and turns it into a single-cycle
//   inc/add/sub pulse plus an unsigned offset magnitude on the PC's control pins. Holds a
//   return-address stack (RAS) so returns can be expressed as relative PC moves.
// PARAMETERS
//   WIDTH      16  PC / offset width in bits
//   RAS_DEPTH  8   return-address stack entries (power of 2, >=2)
// PORTS
//   clk           in   1      single clock, rising edge
//   reset         in   1      synchronous, active-high
//   op_valid      in   1      op request present
//   op_ready      out  1      op accepted on the cycle where op_valid & op_ready
//   op_code       in   3      0 NEXT, 1 JREL, 2 CALL, 3 RET, 4 HALT; 5-7 treated as NEXT
//   op_offset     in   WIDTH  signed two's-complement displacement (JREL/CALL only)
//   stall         in   1      holds off acceptance; never aborts an issued pulse
//   pc_in         in   WIDTH  current PC value from the PC register
//   pc_inc        out  1      PC increment pulse
//   pc_add        out  1      PC += pc_offset pulse
//   pc_sub        out  1      PC -= pc_offset pulse
//   pc_offset     out  WIDTH  unsigned magnitude for add/sub; 0 when no add/sub pulse
//   halted        out  1      HALT accepted; sticky until reset
//   ras_overflow  out  1      sticky: CALL pushed onto a full RAS
//   ras_underflow out  1      sticky: RET popped an empty RAS
// BEHAVIOUR
//   - Reset (sync): state IDLE, all outputs 0, RAS empty (count 0, pointer 0), flags cleared.
//     Reset wins over every other input in the same cycle, including mid-ISSUE.
//   - FSM: IDLE -> ISSUE -> IDLE; IDLE -> HALT_ST on HALT; HALT_ST is left only via reset.
//   - op_ready = (state==IDLE) & ~stall. It is combinational from state and stall only.
//   - Accept in IDLE: decode op, register pulse + offset, go to ISSUE. In ISSUE exactly one
//     of pc_inc/pc_add/pc_sub is 1 for exactly one cycle. PC updates on the edge ending ISSUE.
//     pc_in is therefore valid again in the next IDLE. Throughput: 1 op per 2 cycles.
//   - Outputs are registered. pc_inc/pc_add/pc_sub are mutually exclusive and 0 outside ISSUE.
//   - NEXT: pc_inc, pc_offset=0.
//   - JREL: d=op_offset. If d[WIDTH-1]==0: pc_add, offset=d. Otherwise: pc_sub, offset=-d
//     (mod 2^WIDTH). d=0x8000 gives pc_sub with offset 0x8000.
//   - CALL: push (pc_in+1) mod 2^WIDTH, then act as JREL with op_offset.
//   - RET with count>0: pop top T; delta=(T-pc_in) mod 2^WIDTH. If delta MSB=0: pc_add with
//     offset delta (delta=0 still gives pc_add with offset 0). Otherwise: pc_sub with offset -delta.
//   - RET with count==0: set ras_underflow, behave as NEXT.
//   - RAS is a circular buffer. Push when count==RAS_DEPTH overwrites the oldest entry, keeps
//     count at RAS_DEPTH, and sets ras_overflow.
//   - HALT: no pulse is issued; halted=1 from the next cycle; op_ready stays 0.
//   - stall during ISSUE has no effect. stall in IDLE blocks acceptance only; no state changes.
// STRUCTURE
//   - Package pc_seq_pkg: op_code localparams (OP_NEXT..OP_HALT), FSM state encoding, and a
//     function to_mag(signed) -> {is_neg, magnitude}.
//   - Sub-module pc_seq_ras: parameterised LIFO, synchronous push/pop, count, full/empty.
//     Push and pop never both fire in one cycle.
//   - Top: FSM, decode, and delta/magnitude arithmetic (WIDTH-bit, wrap mod 2^WIDTH).
// TESTING  (pc model: reset 0, inc +1, add +off, sub -off)
//   - reset; NEXT x3 -> pc_inc pulses at cycles 2,4,6, each 1 cycle wide; pc ends at 3; flags 0.
//   - pc=0x0010. JREL 0xFFFC -> pc_sub, offset 0x0004, pc=0x000C.
//     Then JREL 0x8000 -> pc_sub, offset 0x8000, pc=0x800C.
//   - pc=0x0100. CALL +0x0040 -> push 0x0101, pc=0x0140. RET -> pc_sub, offset 0x003F, pc=0x0101.
//     RAS now empty.
//   - 9 CALLs with RAS_DEPTH=8 -> ras_overflow=1 after the 9th. 8 RETs then restore the
//     return addresses of calls 9..2. The 9th RET sets ras_underflow and produces pc_inc.
//   - Hold stall=1 with op_valid=1 for 5 cycles -> op_ready=0 and no pulses.
//     Raising stall during ISSUE -> the pulse still completes.
//   - HALT -> halted=1 and op_ready=0 forever. Assert reset mid-ISSUE -> pulse cleared the
//     next cycle, all outputs 0, RAS empty.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC control-flow sequencer.
//   - op_code encodings (OP_NEXT..OP_HALT; unlisted codes behave as OP_NEXT)
//   - sequencer FSM state encoding
//   - to_mag(): split a two's-complement value into {is_neg, magnitude}
package pc_seq_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JREL = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHalt  = 2'd2
  } state_e;

  // Wide enough for any supported PC width; callers pass the live width in.
  localparam int unsigned MagMaxWidth = 64;

  typedef struct packed {
    logic                   is_neg;
    logic [MagMaxWidth-1:0] mag;
  } mag_t;

  // Treats the low 'width' bits of value as a signed number and returns its sign plus the
  // unsigned magnitude modulo 2^width (so the most negative value maps onto itself).
  function automatic mag_t to_mag(input logic [MagMaxWidth-1:0] value,
                                  input int unsigned            width);
    mag_t                   r;
    logic [MagMaxWidth-1:0] mask;
    mask     = (width >= MagMaxWidth) ? '1 : ((64'd1 << width) - 64'd1);
    r.is_neg = |((value >> (width - 1)) & 64'd1);
    r.mag    = r.is_neg ? ((~value + 64'd1) & mask) : (value & mask);
    return r;
  endfunction

endpackage

// File: rtl/pc_seq_ras.sv
// Return-address stack: circular LIFO with synchronous push/pop.
// A push onto a full stack overwrites the oldest entry and keeps the count saturated.
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties the stack)
//   push, push_data     write push_data on top
//   pop                 discard the top entry (ignored when empty)
//   top_data            current top entry (undefined when empty)
//   full, empty         occupancy flags
module pc_seq_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q;   // next slot to write; also the oldest slot when full
  logic [PtrW:0]    count_q;

  assign full     = (count_q == CntMax);
  assign empty    = (count_q == '0);
  assign top_data = mem[ptr_q - PtrOne];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrOne;
      if (!full) count_q <= count_q + CntOne;
    end else if (pop && !empty) begin
      ptr_q   <= ptr_q - PtrOne;
      count_q <= count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Control-flow sequencer for the program counter. Accepts one op at a time and turns it into
// a single-cycle inc/add/sub pulse plus an unsigned offset magnitude. Returns are expressed as
// relative moves from the current PC to the address popped off the return-address stack.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   op_valid/op_ready              op handshake; op_ready = idle & ~stall
//   op_code, op_offset             op (NEXT/JREL/CALL/RET/HALT) and signed displacement
//   stall                          blocks acceptance only
//   pc_in                          current PC value
//   pc_inc/pc_add/pc_sub/pc_offset registered PC control, valid for the one ISSUE cycle
//   halted, ras_overflow, ras_underflow   sticky status flags
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_offset,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_inc,
  output logic             pc_add,
  output logic             pc_sub,
  output logic [WIDTH-1:0] pc_offset,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  state_e           state_q, state_d;
  logic             inc_q, inc_d, add_q, add_d, sub_q, sub_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic             halted_q, halted_d, ovf_q, ovf_d, unf_q, unf_d;

  logic             accept;
  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic [WIDTH-1:0] ras_top, ret_addr, ret_delta;
  mag_t             jrel_m, ret_m;
  logic             unused_mag_hi;

  assign op_ready  = (state_q == StIdle) && !stall;
  assign accept    = op_valid && op_ready;
  assign ret_addr  = pc_in + WIDTH'(1);
  assign ret_delta = ras_top - pc_in;
  assign jrel_m    = to_mag(MagMaxWidth'(op_offset), WIDTH);
  assign ret_m     = to_mag(MagMaxWidth'(ret_delta), WIDTH);
  assign unused_mag_hi = ^{jrel_m.mag[MagMaxWidth-1:WIDTH], ret_m.mag[MagMaxWidth-1:WIDTH]};

  pc_seq_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .push_data (ret_addr),
    .pop       (ras_pop),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    state_d  = state_q;
    inc_d    = 1'b0;
    add_d    = 1'b0;
    sub_d    = 1'b0;
    off_d    = '0;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          case (op_code)
            OP_JREL: begin
              add_d = !jrel_m.is_neg;
              sub_d = jrel_m.is_neg;
              off_d = jrel_m.mag[WIDTH-1:0];
            end
            OP_CALL: begin
              ras_push = 1'b1;
              if (ras_full) ovf_d = 1'b1;
              add_d = !jrel_m.is_neg;
              sub_d = jrel_m.is_neg;
              off_d = jrel_m.mag[WIDTH-1:0];
            end
            OP_RET: begin
              if (ras_empty) begin
                unf_d = 1'b1;
                inc_d = 1'b1;
              end else begin
                ras_pop = 1'b1;
                add_d   = !ret_m.is_neg;
                sub_d   = ret_m.is_neg;
                off_d   = ret_m.mag[WIDTH-1:0];
              end
            end
            OP_HALT: begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end
            default: inc_d = 1'b1;
          endcase
        end
      end
      // Pulse registers are already loaded; they drop back to 0 on the way out.
      StIssue: state_d = StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      inc_q    <= 1'b0;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      off_q    <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      add_q    <= add_d;
      sub_q    <= sub_d;
      off_q    <= off_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign pc_inc        = inc_q;
  assign pc_add        = add_q;
  assign pc_sub        = sub_q;
  assign pc_offset     = off_q;
  assign halted        = halted_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: a PC register driven by the DUT pulses, a table of ops with
// hand-derived expected pulses, a small RAS model for longer sequences, and a scoreboard
// queue that is popped whenever a pulse appears.
module tb_pc_seq_ctrl;

  localparam logic [1:0] KNone = 2'd0, KInc = 2'd1, KAdd = 2'd2, KSub = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [15:0] op_offset = 16'h0;
  logic        stall = 1'b0;
  logic [15:0] pc;
  logic        pc_inc, pc_add, pc_sub, halted, ras_overflow, ras_underflow;
  logic [15:0] pc_offset;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] off;
  } exp_t;
  exp_t sb[$];

  logic [15:0] ras_m[$];

  typedef struct {
    logic        load;
    logic [15:0] pc0;
    logic [2:0]  op;
    logic [15:0] off;
    logic [1:0]  kind;
    logic [15:0] eoff;
    logic [15:0] epc;
  } vec_t;
  vec_t vecs[16];

  pc_seq_ctrl #(
    .WIDTH     (16),
    .RAS_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_code       (op_code),
    .op_offset     (op_offset),
    .stall         (stall),
    .pc_in         (pc),
    .pc_inc        (pc_inc),
    .pc_add        (pc_add),
    .pc_sub        (pc_sub),
    .pc_offset     (pc_offset),
    .halted        (halted),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Program counter register controlled by the DUT.
  always @(posedge clk) begin
    if (reset)        pc <= 16'h0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc + 16'h1;
    else if (pc_add)  pc <= pc + pc_offset;
    else if (pc_sub)  pc <= pc - pc_offset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] dut_kind();
    if (pc_inc) return KInc;
    if (pc_add) return KAdd;
    if (pc_sub) return KSub;
    return KNone;
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int   np;
    exp_t e;
    np = int'(pc_inc) + int'(pc_add) + int'(pc_sub);
    if (np > 1) chk("pulse_onehot", np, 1);
    if (np != 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", dut_kind(), KNone);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", dut_kind(), e.kind);
        chk("pulse_offset", pc_offset, e.off);
      end
    end else if (pc_offset != 16'h0) begin
      chk("idle_offset_zero", pc_offset, 16'h0);
    end
  end

  // Reference behaviour for one accepted op at the given PC; updates the RAS model.
  task automatic model_op(input logic [2:0] op, input logic [15:0] off, input logic [15:0] cur,
                          output logic [1:0] kind, output logic [15:0] mag);
    logic [15:0] t, d;
    kind = KInc;
    mag  = 16'h0;
    if (op == 3'd4) begin
      kind = KNone;
    end else if (op == 3'd1 || op == 3'd2) begin
      if (op == 3'd2) begin
        ras_m.push_back(cur + 16'h1);
        if (ras_m.size() > 8) void'(ras_m.pop_front());
      end
      kind = off[15] ? KSub : KAdd;
      mag  = off[15] ? (16'h0 - off) : off;
    end else if (op == 3'd3 && ras_m.size() > 0) begin
      t    = ras_m.pop_back();
      d    = t - cur;
      kind = d[15] ? KSub : KAdd;
      mag  = d[15] ? (16'h0 - d) : d;
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  // Present one op, wait (bounded) for acceptance, queue its expected pulse, then let
  // the ISSUE cycle finish. Returns just after the edge that ends ISSUE.
  task automatic do_op(input logic [2:0] op, input logic [15:0] off,
                       input bit use_tbl, input logic [1:0] tkind, input logic [15:0] toff);
    bit          got;
    logic [1:0]  k;
    logic [15:0] m;
    exp_t        e;
    got = 1'b0;
    op_valid = 1'b1;
    op_code = op;
    op_offset = off;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (op_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("ready_timeout", op_ready, 1);
      op_valid = 1'b0;
      return;
    end
    model_op(op, off, pc, k, m);
    e.kind = use_tbl ? tkind : k;
    e.off  = use_tbl ? toff : m;
    if (e.kind != KNone) sb.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ras_m.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] pc_hold, exp_pc;
    exp_t        e;

    //         load  pc0       op    off       kind  eoff      epc
    vecs[0]  = '{1'b1, 16'h0000, 3'd0, 16'h0000, KInc, 16'h0000, 16'h0001};
    vecs[1]  = '{1'b0, 16'h0000, 3'd0, 16'h0000, KInc, 16'h0000, 16'h0002};
    vecs[2]  = '{1'b0, 16'h0000, 3'd0, 16'h0000, KInc, 16'h0000, 16'h0003};
    vecs[3]  = '{1'b1, 16'h0010, 3'd1, 16'hFFFC, KSub, 16'h0004, 16'h000C};
    vecs[4]  = '{1'b0, 16'h0000, 3'd1, 16'h8000, KSub, 16'h8000, 16'h800C};
    vecs[5]  = '{1'b1, 16'h0100, 3'd2, 16'h0040, KAdd, 16'h0040, 16'h0140};
    vecs[6]  = '{1'b0, 16'h0000, 3'd3, 16'h0000, KSub, 16'h003F, 16'h0101};
    vecs[7]  = '{1'b0, 16'h0000, 3'd5, 16'h1234, KInc, 16'h0000, 16'h0102};
    vecs[8]  = '{1'b0, 16'h0000, 3'd7, 16'h0000, KInc, 16'h0000, 16'h0103};
    vecs[9]  = '{1'b0, 16'h0000, 3'd1, 16'h0000, KAdd, 16'h0000, 16'h0103};
    vecs[10] = '{1'b0, 16'h0000, 3'd1, 16'h7FFF, KAdd, 16'h7FFF, 16'h8102};
    vecs[11] = '{1'b0, 16'h0000, 3'd2, 16'h0000, KAdd, 16'h0000, 16'h8102};
    vecs[12] = '{1'b0, 16'h0000, 3'd3, 16'h0000, KAdd, 16'h0001, 16'h8103};
    vecs[13] = '{1'b0, 16'h0000, 3'd2, 16'h0001, KAdd, 16'h0001, 16'h8104};
    vecs[14] = '{1'b0, 16'h0000, 3'd3, 16'h0000, KAdd, 16'h0000, 16'h8104};
    vecs[15] = '{1'b0, 16'h0000, 3'd6, 16'hFFFF, KInc, 16'h0000, 16'h8105};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {pc_inc, pc_add, pc_sub, pc_offset, halted, ras_overflow, ras_underflow},
        22'h0);
    chk("rst_ready", op_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven ops
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].load) load_pc(vecs[i].pc0);
      do_op(vecs[i].op, vecs[i].off, 1'b1, vecs[i].kind, vecs[i].eoff);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
    end
    chk("tbl_flags", {halted, ras_overflow, ras_underflow}, 3'b000);

    // RAS overflow / unwind
    load_pc(16'h1000);
    for (int j = 1; j <= 9; j++) begin
      do_op(3'd2, 16'h0100, 1'b0, KNone, 16'h0);
      if (j == 8) chk("ovf_after_8", ras_overflow, 0);
    end
    chk("ovf_after_9", ras_overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      do_op(3'd3, 16'h0, 1'b0, KNone, 16'h0);
      exp_pc = 16'(32'h1000 + 32'h100 * (9 - i) + 1);
      chk($sformatf("ret%0d_pc", i), pc, exp_pc);
    end
    chk("unf_before", ras_underflow, 0);
    do_op(3'd3, 16'h0, 1'b0, KNone, 16'h0);
    chk("unf_after", ras_underflow, 1);
    chk("ret9_pc", pc, 16'h1102);

    // Stall holds off acceptance
    pc_hold = pc;
    stall = 1'b1;
    op_valid = 1'b1;
    op_code = 3'd0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_ready", op_ready, 0);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    op_valid = 1'b0;
    chk("stall_pc", pc, pc_hold);

    // Stall raised during ISSUE does not cancel the pulse
    op_valid = 1'b1;
    op_code = 3'd1;
    op_offset = 16'h0003;
    @(negedge clk);
    chk("issue_ready", op_ready, 1);
    e.kind = KAdd;
    e.off = 16'h0003;
    sb.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b0;
    stall = 1'b1;
    @(posedge clk); #1;
    chk("stall_issue_pc", pc, pc_hold + 16'h0003);
    stall = 1'b0;

    // HALT is terminal until reset
    do_op(3'd4, 16'h0, 1'b0, KNone, 16'h0);
    op_valid = 1'b1;
    op_code = 3'd0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_ready", op_ready, 0);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("halt_pc", pc, pc_hold + 16'h0003);
    do_reset();
    @(negedge clk);
    chk("halt_cleared", {halted, ras_overflow, ras_underflow, op_ready}, 4'b0001);

    // Reset during ISSUE
    @(posedge clk); #1;
    load_pc(16'h0200);
    do_op(3'd2, 16'h0010, 1'b0, KNone, 16'h0);
    op_valid = 1'b1;
    op_code = 3'd1;
    op_offset = 16'h0020;
    @(negedge clk);
    chk("midrst_ready", op_ready, 1);
    e.kind = KAdd;
    e.off = 16'h0020;
    sb.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("midrst_outputs", {pc_inc, pc_add, pc_sub, pc_offset, halted, ras_overflow,
        ras_underflow}, 22'h0);
    chk("midrst_ready", op_ready, 1);
    chk("midrst_pc", pc, 16'h0000);
    @(posedge clk); #1;
    do_op(3'd3, 16'h0, 1'b0, KNone, 16'h0);
    chk("midrst_ras_empty", ras_underflow, 1);
    chk("midrst_ret_pc", pc, 16'h0001);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
